csa_accum_ctrl: RTL and testbench

CSA_ACCUM_CTRL -- requirements
Module: csa_accum_ctrl

---
 rtl/csa_accum_pkg.sv | 15 +
 rtl/csa_accum_ctrl_csa.sv | 23 ++
 rtl/csa_accum_ctrl.sv | 126 ++++++++++++
 tb/tb_csa_accum_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_accum_pkg.sv
// csa_accum_pkg: shared types and widths for the carry-save accumulator.
// Holds the FSM state enum, the operand width and the operand-count width.
package csa_accum_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_RESOLVE,
        ST_OUTPUT
    } state_t;

endpackage

// File: rtl/csa_accum_ctrl_csa.sv
// carry_save_adder: W-bit 3:2 compressor.
// Ports: a, b, c operands; sum = a^b^c; carry = majority shifted up one bit.
module carry_save_adder
    import csa_accum_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    logic [W-1:0] maj;

    assign sum   = a ^ b ^ c;
    assign maj   = (a & b) | (a & c) | (b & c);
    // Carry is stored at carry weight; the top majority bit falls off
    // because the result is modulo 2^W.
    assign carry = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl: accumulates a group of 16-bit operands in carry-save form
// and resolves S+C once per group (closed by in_last or MAX_OPS operands).
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_data/in_last
// operand stream; out_valid/out_ready/out_data/out_trunc result; busy.
// Optional: define CSA_ACCUM_CNT_EN to add op_count[7:0] (operands in group).
module csa_accum_ctrl
    import csa_accum_pkg::*;
#(
    parameter int MAX_OPS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_trunc,
    output logic              busy
`ifdef CSA_ACCUM_CNT_EN
    ,
    output logic [CNT_W-1:0]  op_count
`endif
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);

    state_t            state;
    logic [DATA_W-1:0] s_q;
    logic [DATA_W-1:0] c_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              trunc_q;

    logic [DATA_W-1:0] csa_a;
    logic [DATA_W-1:0] csa_b;
    logic [DATA_W-1:0] csa_sum;
    logic [DATA_W-1:0] csa_carry;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              accept;
    logic              hit_max;

    // in_ready is gated by rst_n so it reads 0 while reset is held and 1
    // as soon as reset releases, without waiting for a clock edge.
    assign in_ready = rst_n & ((state == ST_IDLE) | (state == ST_ACCUM));
    assign accept   = in_valid & in_ready;

    // Feeding zeros in IDLE makes the compressor produce S=in_data, C=0,
    // so the first beat shares the same update path as later ones.
    assign csa_a = (state == ST_IDLE) ? '0 : s_q;
    assign csa_b = (state == ST_IDLE) ? '0 : c_q;

    assign cnt_nxt = cnt_q + CNT_W'(1);
    assign hit_max = (cnt_nxt == MAX_CNT);

    carry_save_adder #(
        .W     (DATA_W)
    ) u_csa (
        .a     (csa_a),
        .b     (csa_b),
        .c     (in_data),
        .sum   (csa_sum),
        .carry (csa_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            s_q       <= '0;
            c_q       <= '0;
            cnt_q     <= '0;
            trunc_q   <= 1'b0;
            out_data  <= '0;
            out_trunc <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
`ifdef CSA_ACCUM_CNT_EN
            op_count  <= '0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        s_q     <= csa_sum;
                        c_q     <= csa_carry;
                        cnt_q   <= CNT_W'(1);
                        trunc_q <= 1'b0;
                        busy    <= 1'b1;
                        state   <= in_last ? ST_RESOLVE : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        s_q   <= csa_sum;
                        c_q   <= csa_carry;
                        cnt_q <= cnt_nxt;
                        if (in_last || hit_max) begin
                            // in_last wins: a group that ends exactly on
                            // the limit is not truncated.
                            trunc_q <= ~in_last;
                            state   <= ST_RESOLVE;
                        end
                    end
                end
                ST_RESOLVE: begin
                    out_data  <= s_q + c_q;
                    out_trunc <= trunc_q;
`ifdef CSA_ACCUM_CNT_EN
                    op_count  <= cnt_q;
`endif
                    out_valid <= 1'b1;
                    state     <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// tb_csa_accum_ctrl: self-checking bench for csa_accum_ctrl (MAX_OPS=4).
// Directed table, hand-written timing/reset sequences, random scoreboard.
module tb_csa_accum_ctrl;
    import csa_accum_pkg::*;

    localparam int MOPS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_trunc;
    logic        busy;
`ifdef CSA_ACCUM_CNT_EN
    logic [7:0]  op_count;
`endif

    always #5 clk = ~clk;

    csa_accum_ctrl #(
        .MAX_OPS   (MOPS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_trunc (out_trunc),
        .busy      (busy)
`ifdef CSA_ACCUM_CNT_EN
        ,
        .op_count  (op_count)
`endif
    );

    typedef struct {
        logic [15:0] data;
        logic        trunc;
        logic [7:0]  cnt;
    } res_t;

    typedef struct {
        logic [15:0] d;
        logic        l;
        logic        has;
        logic [15:0] ed;
        logic        et;
        logic [7:0]  ec;
    } vec_t;

    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_en = 0;
    bit   rnd_rdy = 0;
    res_t exp_q[$];
    res_t got_q[$];
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            res_t r;
            r.data  = out_data;
            r.trunc = out_trunc;
`ifdef CSA_ACCUM_CNT_EN
            r.cnt   = op_count;
`else
            r.cnt   = '0;
`endif
            got_q.push_back(r);
        end
    end

    // One clock: inputs change 2 time units after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
        if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_beat(input logic [15:0] d, input logic l);
        int  w;
        bit  acc;
        w = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        forever begin
            @(negedge clk);
            acc = in_ready;
            cyc();
            if (acc) break;
            w++;
            if (w > 100) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_timeout: in_ready stuck 0");
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic add_vec(input logic [15:0] d, input logic l,
                           input logic has, input logic [15:0] ed,
                           input logic et, input logic [7:0] ec);
        vec_t v;
        v.d = d; v.l = l; v.has = has;
        v.ed = ed; v.et = et; v.ec = ec;
        tbl.push_back(v);
    endtask

    task automatic drain_compare(input string tag);
        int w;
        int n;
        w = 0;
        while (got_q.size() < exp_q.size() && w < 300) begin
            cyc();
            w++;
        end
        repeat (5) cyc();
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data[%0d]", tag, i),
                got_q[i].data, exp_q[i].data);
            chk($sformatf("%s_trunc[%0d]", tag, i),
                got_q[i].trunc, exp_q[i].trunc);
`ifdef CSA_ACCUM_CNT_EN
            chk($sformatf("%s_opcnt[%0d]", tag, i),
                got_q[i].cnt, exp_q[i].cnt);
`endif
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [15:0] m_sum;
        int          m_n;
        logic [15:0] d;
        logic        l;
        res_t        r;

        // ---------------- reset ----------------
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_data", out_data, 0);
        chk("rel_out_trunc", out_trunc, 0);
        cyc();

        // ---------------- 1+2+3, latency ----------------
        send_beat(16'd1, 1'b0);
        send_beat(16'd2, 1'b0);
        send_beat(16'd3, 1'b1);
        @(negedge clk);
        chk("lat_valid_c1", out_valid, 0);
        chk("lat_busy_c1", busy, 1);
        chk("lat_ready_c1", in_ready, 0);
        @(negedge clk);
        chk("lat_valid_c2", out_valid, 1);
        chk("sum123_data", out_data, 6);
        chk("sum123_trunc", out_trunc, 0);
`ifdef CSA_ACCUM_CNT_EN
        chk("sum123_opcnt", op_count, 3);
`endif
        @(negedge clk);
        chk("sum123_idle_valid", out_valid, 0);
        chk("sum123_idle_busy", busy, 0);
        cyc();

        // ---------------- back-pressure in OUTPUT ----------------
        out_ready = 1'b0;
        send_beat(16'h1234, 1'b1);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("hold_valid[%0d]", k), out_valid, 1);
            chk($sformatf("hold_data[%0d]", k), out_data, 16'h1234);
            chk($sformatf("hold_ready[%0d]", k), in_ready, 0);
            chk($sformatf("hold_busy[%0d]", k), busy, 1);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
        @(negedge clk);
        chk("hold_valid_c6", out_valid, 1);
        @(negedge clk);
        chk("hold_done_busy", busy, 0);
        chk("hold_done_ready", in_ready, 1);
        chk("hold_done_valid", out_valid, 0);
        cyc();

        // ---------------- reset mid-ACCUM ----------------
        send_beat(16'd5, 1'b0);
        send_beat(16'd6, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", in_ready, 0);
        chk("midrst_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_rel_ready", in_ready, 1);
        send_beat(16'd5, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("midrst_new_valid", out_valid, 1);
        chk("midrst_new_data", out_data, 5);
        chk("midrst_new_trunc", out_trunc, 0);
        cyc();
        cyc();

        // ---------------- directed table ----------------
        add_vec(16'h1234, 1, 1, 16'h1234, 0, 1);
        add_vec(16'hFFFF, 0, 0, 0, 0, 0);
        add_vec(16'h0001, 1, 1, 16'h0000, 0, 2);
        add_vec(16'd1, 0, 0, 0, 0, 0);
        add_vec(16'd1, 0, 0, 0, 0, 0);
        add_vec(16'd1, 0, 0, 0, 0, 0);
        add_vec(16'd1, 0, 1, 16'd4, 1, 4);
        add_vec(16'd1, 0, 0, 0, 0, 0);
        add_vec(16'd7, 1, 1, 16'd8, 0, 2);
        add_vec(16'd10, 0, 0, 0, 0, 0);
        add_vec(16'd20, 0, 0, 0, 0, 0);
        add_vec(16'd30, 0, 0, 0, 0, 0);
        add_vec(16'd40, 1, 1, 16'd100, 0, 4);
        add_vec(16'h8000, 0, 0, 0, 0, 0);
        add_vec(16'h8000, 0, 0, 0, 0, 0);
        add_vec(16'h7FFF, 1, 1, 16'h7FFF, 0, 3);
        add_vec(16'hAAAA, 0, 0, 0, 0, 0);
        add_vec(16'h5555, 0, 0, 0, 0, 0);
        add_vec(16'hFFFF, 0, 0, 0, 0, 0);
        add_vec(16'h0002, 0, 1, 16'h0000, 1, 4);

        mon_en = 1;
        foreach (tbl[i]) begin
            send_beat(tbl[i].d, tbl[i].l);
            if (tbl[i].has) begin
                r.data  = tbl[i].ed;
                r.trunc = tbl[i].et;
                r.cnt   = tbl[i].ec;
                exp_q.push_back(r);
            end
        end
        drain_compare("tbl");

        // ---------------- random vs reference model ----------------
        m_sum = '0;
        m_n   = 0;
        rnd_rdy = 1;
        for (int i = 0; i < 400; i++) begin
            d = 16'($urandom);
            l = ($urandom_range(0, 4) == 0) || (i == 399);
            m_sum = m_sum + d;
            m_n   = m_n + 1;
            if (l || m_n == MOPS) begin
                r.data  = m_sum;
                r.trunc = !l;
                r.cnt   = 8'(m_n);
                exp_q.push_back(r);
                m_sum = '0;
                m_n   = 0;
            end
            repeat ($urandom_range(0, 2)) cyc();
            send_beat(d, l);
        end
        rnd_rdy = 0;
        out_ready = 1'b1;
        drain_compare("rnd");
        mon_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
